// File: rtl/maze_grid_ctrl.sv
// Maze grid owner: 4x5 cell state, GPIO packet sequencer and registered VGA read port.
// Define MAZE_GRID_FRONTIER_EN to mark unvisited neighbours of each new cell as 11.
`timescale 1ns/1ps
module maze_grid_ctrl #(
    parameter int unsigned ROWS    = 4,
    parameter int unsigned COLS    = 5,
    parameter int unsigned CELL_PX = 50
) (
    input  logic       CLOCK,
    input  logic       RESET_N,
    input  logic [4:0] PKT_DATA,
    input  logic       PKT_STROBE,
    output logic       PKT_ACK,
    input  logic [9:0] PIXEL_X,
    input  logic [9:0] PIXEL_Y,
    output logic [1:0] GRID_DATA,
    output logic [4:0] CUR_POS,
    output logic       CUR_VALID,
    output logic [4:0] VISIT_COUNT,
    output logic       DONE,
    output logic       ERR_PKT
);

    localparam int unsigned CELLS   = ROWS * COLS;
    localparam logic [4:0]  CELLS_W = 5'(CELLS);

    localparam logic [1:0] CELL_UNVISITED = 2'b00;
    localparam logic [1:0] CELL_VISITED   = 2'b01;
    localparam logic [1:0] CELL_CURRENT   = 2'b10;
    localparam logic [1:0] CELL_FUTURE    = 2'b11;

    typedef enum logic [3:0] {
        StIdle,
        StLatch,
        StWrOld,
        StWrNew,
`ifdef MAZE_GRID_FRONTIER_EN
        StFrN,
        StFrS,
        StFrW,
        StFrE,
`endif
        StAckHi
    } state_e;

    function automatic logic [4:0] cell_idx(input logic [1:0] row, input logic [2:0] col);
        return 5'(row) * 5'(COLS) + 5'(col);
    endfunction

    logic       r_stb_meta, r_stb_sync;
    logic [4:0] r_data_meta, r_data_sync;
    state_e     r_state, w_state_next;
    logic       r_ack;
    logic [1:0] r_grid [CELLS];
    logic [1:0] r_new_row, r_cur_row;
    logic [2:0] r_new_col, r_cur_col;
    logic       r_cur_valid;
    logic [4:0] r_visit;
    logic       r_err;
    logic [1:0] r_grid_data;

    logic [1:0] w_pkt_row;
    logic [2:0] w_pkt_col;
    logic       w_pkt_bad, w_pkt_dup;
    logic [4:0] w_new_idx, w_cur_idx;
    logic [4:0] w_fsm_raddr;
    logic [1:0] w_fsm_rdata;
    logic       w_we;
    logic [4:0] w_waddr;
    logic [1:0] w_wdata;
    logic [9:0] w_vga_col, w_vga_row;
    logic       w_vga_in;
    logic [4:0] w_vga_idx;

    assign w_pkt_row = r_data_sync[1:0];
    assign w_pkt_col = r_data_sync[4:2];
    assign w_pkt_bad = (int'(w_pkt_col) >= COLS) || (int'(w_pkt_row) >= ROWS);
    assign w_pkt_dup = r_cur_valid && (w_pkt_row == r_cur_row) && (w_pkt_col == r_cur_col);
    assign w_new_idx = cell_idx(r_new_row, r_new_col);
    assign w_cur_idx = cell_idx(r_cur_row, r_cur_col);

    // FSM read port; out-of-range addresses only occur for skipped neighbours.
    assign w_fsm_rdata = (int'(w_fsm_raddr) < CELLS) ? r_grid[w_fsm_raddr] : CELL_UNVISITED;

    assign w_vga_col = PIXEL_X / 10'(CELL_PX);
    assign w_vga_row = PIXEL_Y / 10'(CELL_PX);
    assign w_vga_in  = (int'(w_vga_col) < COLS) && (int'(w_vga_row) < ROWS);
    assign w_vga_idx = cell_idx(w_vga_row[1:0], w_vga_col[2:0]);

`ifdef MAZE_GRID_FRONTIER_EN
    logic       w_nb_ok;
    logic [4:0] w_nb_idx;

    always_comb begin
        w_nb_ok  = 1'b0;
        w_nb_idx = w_cur_idx;
        case (r_state)
            StFrN: begin
                w_nb_ok  = (r_cur_row != 2'd0);
                w_nb_idx = cell_idx(r_cur_row - 2'd1, r_cur_col);
            end
            StFrS: begin
                w_nb_ok  = (int'(r_cur_row) < ROWS - 1);
                w_nb_idx = cell_idx(r_cur_row + 2'd1, r_cur_col);
            end
            StFrW: begin
                w_nb_ok  = (r_cur_col != 3'd0);
                w_nb_idx = cell_idx(r_cur_row, r_cur_col - 3'd1);
            end
            StFrE: begin
                w_nb_ok  = (int'(r_cur_col) < COLS - 1);
                w_nb_idx = cell_idx(r_cur_row, r_cur_col + 3'd1);
            end
            default: ;
        endcase
    end
`endif

    always_comb begin
        w_state_next = r_state;
        w_we         = 1'b0;
        w_waddr      = w_new_idx;
        w_wdata      = CELL_CURRENT;
        w_fsm_raddr  = w_new_idx;
        unique case (r_state)
            StIdle:  if (r_stb_sync) w_state_next = StLatch;
            StLatch: w_state_next = (w_pkt_bad || w_pkt_dup) ? StAckHi : StWrOld;
            StWrOld: begin
                w_we         = r_cur_valid;
                w_waddr      = w_cur_idx;
                w_wdata      = CELL_VISITED;
                w_state_next = StWrNew;
            end
            StWrNew: begin
                w_we = 1'b1;
`ifdef MAZE_GRID_FRONTIER_EN
                w_state_next = StFrN;
`else
                w_state_next = StAckHi;
`endif
            end
`ifdef MAZE_GRID_FRONTIER_EN
            StFrN, StFrS, StFrW, StFrE: begin
                w_fsm_raddr = w_nb_idx;
                w_waddr     = w_nb_idx;
                w_wdata     = CELL_FUTURE;
                w_we        = w_nb_ok && (w_fsm_rdata == CELL_UNVISITED);
                case (r_state)
                    StFrN:   w_state_next = StFrS;
                    StFrS:   w_state_next = StFrW;
                    StFrW:   w_state_next = StFrE;
                    default: w_state_next = StAckHi;
                endcase
            end
`endif
            StAckHi: if (!r_stb_sync) w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_stb_meta  <= 1'b0;
            r_stb_sync  <= 1'b0;
            r_data_meta <= '0;
            r_data_sync <= '0;
        end else begin
            r_stb_meta  <= PKT_STROBE;
            r_stb_sync  <= r_stb_meta;
            r_data_meta <= PKT_DATA;
            r_data_sync <= r_data_meta;
        end
    end

    // Ack is registered from the next state so it rises on ACK_HI entry and falls on exit.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= StIdle;
            r_ack   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_ack   <= (w_state_next == StAckHi);
        end
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_new_row   <= '0;
            r_new_col   <= '0;
            r_cur_row   <= '0;
            r_cur_col   <= '0;
            r_cur_valid <= 1'b0;
            r_visit     <= '0;
            r_err       <= 1'b0;
        end else begin
            if (r_state == StLatch) begin
                r_new_row <= w_pkt_row;
                r_new_col <= w_pkt_col;
                if (w_pkt_bad) r_err <= 1'b1;
            end
            if (r_state == StWrNew) begin
                if ((w_fsm_rdata == CELL_UNVISITED || w_fsm_rdata == CELL_FUTURE) &&
                    (r_visit != CELLS_W)) begin
                    r_visit <= r_visit + 5'd1;
                end
                r_cur_row   <= r_new_row;
                r_cur_col   <= r_new_col;
                r_cur_valid <= 1'b1;
            end
        end
    end

    // VGA read samples the pre-write contents in the same edge as a write.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < CELLS; i++) r_grid[i] <= CELL_UNVISITED;
            r_grid_data <= CELL_UNVISITED;
        end else begin
            for (int i = 0; i < CELLS; i++) begin
                if (w_we && (w_waddr == 5'(i))) r_grid[i] <= w_wdata;
            end
            r_grid_data <= w_vga_in ? r_grid[w_vga_idx] : CELL_UNVISITED;
        end
    end

    assign PKT_ACK     = r_ack;
    assign GRID_DATA   = r_grid_data;
    assign CUR_POS     = {r_cur_col, r_cur_row};
    assign CUR_VALID   = r_cur_valid;
    assign VISIT_COUNT = r_visit;
    assign DONE        = (r_visit == CELLS_W);
    assign ERR_PKT     = r_err;

endmodule

// File: tb/tb_maze_grid_ctrl.sv
// Scoreboard bench for maze_grid_ctrl: randomized packets and pixel reads checked against
// a cell-array reference model of the maze rules.
`timescale 1ns/1ps
module tb_maze_grid_ctrl;

    localparam int ROWS    = 4;
    localparam int COLS    = 5;
    localparam int CELL_PX = 50;
`ifdef MAZE_GRID_FRONTIER_EN
    localparam bit FRONTIER = 1'b1;
`else
    localparam bit FRONTIER = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       RESET_N;
    logic [4:0] PKT_DATA;
    logic       PKT_STROBE;
    logic       PKT_ACK;
    logic [9:0] PIXEL_X, PIXEL_Y;
    logic [1:0] GRID_DATA;
    logic [4:0] CUR_POS;
    logic       CUR_VALID;
    logic [4:0] VISIT_COUNT;
    logic       DONE;
    logic       ERR_PKT;

    maze_grid_ctrl #(.ROWS(ROWS), .COLS(COLS), .CELL_PX(CELL_PX)) dut (
        .CLOCK      (clk),
        .RESET_N    (RESET_N),
        .PKT_DATA   (PKT_DATA),
        .PKT_STROBE (PKT_STROBE),
        .PKT_ACK    (PKT_ACK),
        .PIXEL_X    (PIXEL_X),
        .PIXEL_Y    (PIXEL_Y),
        .GRID_DATA  (GRID_DATA),
        .CUR_POS    (CUR_POS),
        .CUR_VALID  (CUR_VALID),
        .VISIT_COUNT(VISIT_COUNT),
        .DONE       (DONE),
        .ERR_PKT    (ERR_PKT)
    );

    always #20 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         raise;
        int         lat;
        logic [4:0] pos;
        logic       valid;
        int         visits;
        logic       err;
    } exp_t;

    exp_t exp_q[$];
    int   pix_q[$];
    int   checks = 0;
    int   errors = 0;
    int   fall_cyc = 0;
    bit   pix_req = 1'b0;

    int m_grid[ROWS][COLS];
    int m_row, m_col, m_visits;
    bit m_valid, m_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void model_reset();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) m_grid[r][c] = 0;
        m_row = 0; m_col = 0; m_visits = 0; m_valid = 0; m_err = 0;
    endfunction

    function automatic exp_t model_apply(input logic [4:0] pkt);
        exp_t e;
        int row = int'(pkt[1:0]);
        int col = int'(pkt[4:2]);
        int nr, nc;
        if (col >= COLS || row >= ROWS) begin
            m_err = 1;
            e.lat = 4;
        end else if (m_valid && row == m_row && col == m_col) begin
            e.lat = 4;
        end else begin
            if (m_valid) m_grid[m_row][m_col] = 1;
            if ((m_grid[row][col] == 0 || m_grid[row][col] == 3) && m_visits < ROWS * COLS)
                m_visits++;
            m_grid[row][col] = 2;
            m_row = row; m_col = col; m_valid = 1;
            if (FRONTIER) begin
                for (int k = 0; k < 4; k++) begin
                    nr = row + ((k == 0) ? -1 : (k == 1) ? 1 : 0);
                    nc = col + ((k == 2) ? -1 : (k == 3) ? 1 : 0);
                    if (nr >= 0 && nr < ROWS && nc >= 0 && nc < COLS && m_grid[nr][nc] == 0)
                        m_grid[nr][nc] = 3;
                end
            end
            e.lat = FRONTIER ? 10 : 6;
        end
        e.raise  = 0;
        e.pos    = {3'(m_col), 2'(m_row)};
        e.valid  = m_valid;
        e.visits = m_visits;
        e.err    = m_err;
        return e;
    endfunction

    function automatic int model_pix(input int x, input int y);
        if (x >= COLS * CELL_PX || y >= ROWS * CELL_PX) return 0;
        return m_grid[y / CELL_PX][x / CELL_PX];
    endfunction

    // Monitor: pops a packet expectation on every ack rise, a pixel expectation per read.
    initial begin
        bit   prev_ack = 1'b0;
        bit   pix_s;
        exp_t e;
        int   lat;
        int   px;
        forever begin
            @(posedge clk);
            pix_s = pix_req;
            #1;
            if (RESET_N) begin
                if (PKT_ACK && !prev_ack) begin
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_ack: got ack rise, expected none (cycle %0d)", cyc);
                    end else begin
                        e = exp_q.pop_front();
                        chk("ack_latency", cyc - e.raise, e.lat);
                        chk("cur_pos", CUR_POS, e.pos);
                        chk("cur_valid", CUR_VALID, e.valid);
                        chk("visit_count", VISIT_COUNT, e.visits);
                        chk("done", DONE, (e.visits == ROWS * COLS) ? 1 : 0);
                        chk("err_pkt", ERR_PKT, e.err);
                    end
                end
                if (!PKT_ACK && prev_ack) begin
                    lat = cyc - fall_cyc;
                    checks++;
                    if (lat < 2 || lat > 3) begin
                        errors++;
                        $display("FAIL ack_drop: got %0d cycles, expected 2..3", lat);
                    end
                end
            end
            if (pix_s) begin
                if (pix_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL pixel_queue: got read with no expectation (cycle %0d)", cyc);
                end else begin
                    px = pix_q.pop_front();
                    chk("grid_data", GRID_DATA, px);
                end
            end
            prev_ack = PKT_ACK;
        end
    end

    task automatic wait_ack(input bit level);
        int t = 0;
        while (PKT_ACK !== level && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (PKT_ACK !== level) begin
            checks++; errors++;
            $display("FAIL ack_timeout: got ack=%0b, expected %0b", PKT_ACK, level);
        end
    endtask

    task automatic raise(input logic [4:0] pkt);
        exp_t e;
        @(negedge clk);
        PKT_DATA = pkt;
        repeat (3) @(negedge clk);
        e = model_apply(pkt);
        e.raise = cyc;
        exp_q.push_back(e);
        PKT_STROBE = 1'b1;
        wait_ack(1'b1);
    endtask

    task automatic send(input logic [4:0] pkt, input int hold);
        raise(pkt);
        repeat (hold) @(negedge clk);
        PKT_STROBE = 1'b0;
        fall_cyc   = cyc;
        wait_ack(1'b0);
        @(negedge clk);
    endtask

    task automatic pix(input int x, input int y);
        @(negedge clk);
        PIXEL_X = 10'(x);
        PIXEL_Y = 10'(y);
        pix_q.push_back(model_pix(x, y));
        pix_req = 1'b1;
        @(negedge clk);
        pix_req = 1'b0;
    endtask

    task automatic sweep();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) pix(c * CELL_PX + 25, r * CELL_PX + 25);
        pix(49, 49); pix(50, 50); pix(249, 199); pix(250, 10); pix(10, 200); pix(1023, 1023);
    endtask

    initial begin
        logic [4:0] p;
        RESET_N = 1'b0; PKT_STROBE = 1'b0; PKT_DATA = '0; PIXEL_X = '0; PIXEL_Y = '0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_ack", PKT_ACK, 0);
        chk("rst_cur_pos", CUR_POS, 0);
        chk("rst_cur_valid", CUR_VALID, 0);
        chk("rst_visits", VISIT_COUNT, 0);
        chk("rst_done", DONE, 0);
        chk("rst_err", ERR_PKT, 0);
        chk("rst_grid_data", GRID_DATA, 0);
        RESET_N = 1'b1;
        @(negedge clk);

        send(5'b00000, 1);  pix(10, 10);
        send(5'b00101, 2);  pix(60, 60); pix(49, 49);
        send(5'b00101, 20); pix(60, 60);
        send(5'b10100, 0);  pix(250, 0); pix(0, 0);
        sweep();

        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) send({3'(c), 2'(r)}, 0);
        send(5'b00000, 1);
        sweep();

        for (int n = 0; n < 40; n++) begin
            p = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 4) == 0) p = {3'(m_col), 2'(m_row)};
            send(p, $urandom_range(0, 4));
            for (int k = 0; k < 3; k++) pix($urandom_range(0, 320), $urandom_range(0, 260));
            if (n % 10 == 9) sweep();
        end

        // Reset while ACK_HI is held: everything returns to reset values.
        raise(5'b01110);
        @(negedge clk);
        RESET_N = 1'b0;
        #1;
        chk("midrst_ack", PKT_ACK, 0);
        chk("midrst_cur_pos", CUR_POS, 0);
        chk("midrst_cur_valid", CUR_VALID, 0);
        chk("midrst_visits", VISIT_COUNT, 0);
        chk("midrst_done", DONE, 0);
        chk("midrst_err", ERR_PKT, 0);
        chk("midrst_grid_data", GRID_DATA, 0);
        PKT_STROBE = 1'b0;
        repeat (3) @(negedge clk);
        model_reset();
        RESET_N = 1'b1;
        @(negedge clk);
        sweep();

        send(5'b00101, 0); sweep();
        send(5'b00110, 1); sweep();

        repeat (5) @(negedge clk);
        chk("exp_queue_drained", exp_q.size(), 0);
        chk("pix_queue_drained", pix_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #4_000_000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "watchdog");
    end

endmodule
